// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction store:
// NOP encoding, loader FSM states and fault bit positions.
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam int FAULT_MISALIGN = 1;
    localparam int FAULT_OOR      = 0;

endpackage

// File: rtl/imem_sram.sv
// Synchronous single-write, single-read RAM.
// The read register only updates when re is high.
module imem_sram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// RAM-backed instruction store with a registered fetch port
// for the IF stage and a sequential program-load port.
module instr_mem_loadable
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(mips_pkg::NOP_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [1:0]        fault,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [DATA_W-1:0] prog_data,
    output logic [ADDR_W:0]   prog_count,
    output logic              prog_full,
    output logic              busy
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

    state_t            state;
    logic              use_mem;
    logic [1:0]        fault_next;
    logic              do_fetch;
    logic              do_write;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        fault_next = 2'b00;
        fault_next[FAULT_MISALIGN] = |fetch_addr[1:0];
        fault_next[FAULT_OOR]      = |fetch_addr[31:ADDR_W+2];
    end

    // RAM read is gated so a stalled fetch keeps its data register intact
    assign do_fetch = (state == ST_RUN) && !prog_en && !flush
                   && !stall && fetch_req;
    assign do_write = (state == ST_LOAD) && prog_en && prog_we && !prog_full;

    imem_sram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (clk),
        .we    (do_write),
        .waddr (prog_count[ADDR_W-1:0]),
        .wdata (prog_data),
        .re    (do_fetch),
        .raddr (fetch_addr[ADDR_W+1:2]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            use_mem     <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 2'b00;
            prog_count  <= '0;
            prog_full   <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (prog_en) begin
                        state       <= ST_LOAD;
                        prog_count  <= '0;
                        prog_full   <= 1'b0;
                        use_mem     <= 1'b0;
                        instr_valid <= 1'b0;
                        fault       <= 2'b00;
                    end else if (flush) begin
                        use_mem     <= 1'b0;
                        instr_valid <= 1'b0;
                        fault       <= 2'b00;
                    end else if (!stall) begin
                        instr_valid <= fetch_req;
                        fault       <= fetch_req ? fault_next : 2'b00;
                        use_mem     <= fetch_req && (fault_next == 2'b00);
                    end
                end
                ST_LOAD: begin
                    if (!prog_en) begin
                        state <= ST_RUN;
                    end else if (do_write) begin
                        prog_count <= prog_count + CNT_ONE;
                        if (prog_count == CNT_LAST) prog_full <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign instr = use_mem ? rdata : NOP_WORD;
    assign busy  = (state == ST_LOAD);

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable with a 16-word store.
module tb_instr_mem_loadable;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic [1:0]  fault;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          stall;
    logic          flush;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [1:0]    fault;
    logic          prog_en;
    logic          prog_we;
    logic [31:0]   prog_data;
    logic [ADDR_W:0] prog_count;
    logic          prog_full;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];
    obs_t last_exp;
    logic [31:0] model_mem [DEPTH];
    int   mcount;

    localparam obs_t NOP_OBS = '{instr: 32'h0, valid: 1'b0, fault: 2'b00};

    instr_mem_loadable #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .stall       (stall),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fault       (fault),
        .prog_en     (prog_en),
        .prog_we     (prog_we),
        .prog_data   (prog_data),
        .prog_count  (prog_count),
        .prog_full   (prog_full),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t model_fetch(input logic [31:0] a);
        obs_t e;
        e.valid = 1'b1;
        e.fault = {|a[1:0], |a[31:ADDR_W+2]};
        e.instr = (e.fault == 2'b00) ? model_mem[a[ADDR_W+1:2]] : 32'h0;
        return e;
    endfunction

    task automatic cyc(input string tag, input logic req,
                       input logic [31:0] a, input logic stl,
                       input logic fl);
        obs_t e;
        obs_t g;
        @(negedge clk);
        fetch_req  = req;
        fetch_addr = a;
        stall      = stl;
        flush      = fl;
        if (fl)       e = NOP_OBS;
        else if (stl) e = last_exp;
        else if (req) e = model_fetch(a);
        else          e = NOP_OBS;
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({tag, ".instr"}, 64'(instr), 64'(g.instr));
        chk({tag, ".valid"}, 64'(instr_valid), 64'(g.valid));
        chk({tag, ".fault"}, 64'(fault), 64'(g.fault));
    endtask

    task automatic enter_load();
        @(negedge clk);
        fetch_req = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        prog_en   = 1'b1;
        prog_we   = 1'b1;
        prog_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mcount   = 0;
        last_exp = NOP_OBS;
        chk("entry.busy", 64'(busy), 64'd1);
        chk("entry.count", 64'(prog_count), 64'd0);
        chk("entry.valid", 64'(instr_valid), 64'd0);
    endtask

    task automatic write_word(input logic [31:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_data = d;
        if (mcount < DEPTH) begin
            model_mem[mcount] = d;
            mcount++;
        end
        @(posedge clk);
        #1;
        chk("wr.count", 64'(prog_count), 64'(mcount));
        chk("wr.full", 64'(prog_full), 64'(mcount == DEPTH));
    endtask

    task automatic exit_load();
        @(negedge clk);
        prog_we = 1'b0;
        prog_en = 1'b0;
        @(posedge clk);
        #1;
        last_exp = NOP_OBS;
        chk("exit.busy", 64'(busy), 64'd0);
        chk("exit.count", 64'(prog_count), 64'(mcount));
        chk("exit.full", 64'(prog_full), 64'(mcount == DEPTH));
    endtask

    initial begin
        reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        stall = 1'b0; flush = 1'b0; prog_en = 1'b0;
        prog_we = 1'b0; prog_data = '0;
        last_exp = NOP_OBS;
        mcount = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
        #3;
        chk("rst.instr", 64'(instr), 64'd0);
        chk("rst.valid", 64'(instr_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.count", 64'(prog_count), 64'd0);
        chk("rst.full", 64'(prog_full), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        enter_load();
        for (int i = 0; i < DEPTH; i++) write_word(32'h1000_0000 + i);
        exit_load();

        cyc("f0c", 1'b1, 32'h0C, 1'b0, 1'b0);
        cyc("f00", 1'b1, 32'h00, 1'b0, 1'b0);
        cyc("f3c", 1'b1, 32'h3C, 1'b0, 1'b0);
        cyc("idle", 1'b0, 32'h08, 1'b0, 1'b0);
        cyc("mis", 1'b1, 32'h02, 1'b0, 1'b0);
        cyc("oor40", 1'b1, 32'h40, 1'b0, 1'b0);
        cyc("oor400", 1'b1, 32'h400, 1'b0, 1'b0);
        cyc("both", 1'b1, 32'h8000_0001, 1'b0, 1'b0);

        cyc("fa", 1'b1, 32'h04, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("stall", 1'b1, 32'h08, 1'b1, 1'b0);
        cyc("flush", 1'b1, 32'h08, 1'b1, 1'b1);
        cyc("stmis", 1'b1, 32'h01, 1'b0, 1'b0);
        cyc("stmis.h", 1'b0, 32'h00, 1'b1, 1'b0);
        cyc("flnoreq", 1'b1, 32'h10, 1'b0, 1'b1);

        enter_load();
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = 32'h04;
        prog_we = 1'b0;
        @(posedge clk);
        #1;
        chk("load.nofetch", 64'(instr_valid), 64'd0);
        fetch_req = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) write_word(32'h2000_0000 + i);
        exit_load();
        cyc("ovf0", 1'b1, 32'h00, 1'b0, 1'b0);
        cyc("ovf15", 1'b1, 32'h3C, 1'b0, 1'b0);

        enter_load();
        for (int i = 0; i < 5; i++) write_word(32'h3000_0000 + i);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid.count", 64'(prog_count), 64'd0);
        chk("mid.busy", 64'(busy), 64'd0);
        chk("mid.valid", 64'(instr_valid), 64'd0);
        @(negedge clk);
        prog_en = 1'b0;
        prog_we = 1'b0;
        reset = 1'b1;
        last_exp = NOP_OBS;
        cyc("mid.w2", 1'b1, 32'h08, 1'b0, 1'b0);
        cyc("mid.w5", 1'b1, 32'h14, 1'b0, 1'b0);

        chk("sb.empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
